// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - UART receive FIFO with first-word-fall-through head byte and sticky status
module uart_rx_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_done,
  input  logic [7:0]       rx_data,
  input  logic [2:0]       rx_error,
  input  logic             rd_en,
  input  logic             clr,
  output logic [7:0]       rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic [7:0]       status
);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             overrun;
  logic [2:0]       err_sticky;
  logic             rx_done_q;

  logic push_evt;
  logic push_cand;
  logic pop;
  logic push;
  logic ovf;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // One event per rising edge of the receiver's level-type done flag.
  assign push_evt  = rx_done & ~rx_done_q;
  assign push_cand = push_evt & (rx_error == 3'b000);
  assign pop       = rd_en & ~empty;
  // When full, a same-cycle pop frees the slot the new byte lands in.
  assign push      = push_cand & (~full | pop);
  assign ovf       = push_cand & full & ~pop;

  assign rd_data = empty ? 8'h00 : mem[rd_ptr];
  assign status  = {3'b000, overrun, err_sticky, ~empty};

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overrun    <= 1'b0;
      err_sticky <= 3'b000;
      rx_done_q  <= 1'b0;
    end else begin
      // Edge tracking runs through clr so a held level does not re-push.
      rx_done_q <= rx_done;
      if (clr) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count      <= '0;
        overrun    <= 1'b0;
        err_sticky <= 3'b000;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (pop && !push) begin
          count <= count - CNT_W'(1);
        end
        if (ovf) begin
          overrun <= 1'b1;
        end
        if (push_evt && (rx_error != 3'b000)) begin
          err_sticky <= err_sticky | rx_error;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - directed self-checking bench for uart_rx_buffer
module tb_uart_rx_buffer;

  logic       clk;
  logic       reset;
  logic       rx_done;
  logic [7:0] rx_data;
  logic [2:0] rx_error;
  logic       rd_en;
  logic       clr;
  logic [7:0] rd_data;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic [7:0] status;

  int total = 0;
  int bad   = 0;

  uart_rx_buffer #(.DEPTH(8), .PTR_W(3), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .rx_error (rx_error),
    .rd_en    (rd_en),
    .clr      (clr),
    .rd_data  (rd_data),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .status   (status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] d, input logic [2:0] e);
    rx_data  = d;
    rx_error = e;
    rx_done  = 1'b1;
    tick();
    rx_done  = 1'b0;
    rx_error = 3'b000;
    tick();
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b1;
    rx_done  = 1'b0;
    rx_data  = 8'h00;
    rx_error = 3'b000;
    rd_en    = 1'b0;
    clr      = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    chk("rst_count", {4'h0, count}, 8'h00);
    chk("rst_empty", {7'h0, empty}, 8'h01);
    chk("rst_full", {7'h0, full}, 8'h00);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_status", status, 8'h00);

    // three clean bytes, then drain in order
    pulse(8'hA5, 3'b000);
    chk("p1_count", {4'h0, count}, 8'h01);
    pulse(8'h3C, 3'b000);
    pulse(8'hFF, 3'b000);
    chk("p3_count", {4'h0, count}, 8'h03);
    chk("p3_head", rd_data, 8'hA5);
    chk("p3_status", status, 8'h01);
    chk("pop0", rd_data, 8'hA5);
    pop_one();
    chk("pop1", rd_data, 8'h3C);
    pop_one();
    chk("pop2", rd_data, 8'hFF);
    pop_one();
    chk("drain_empty", {7'h0, empty}, 8'h01);
    chk("drain_rd_data", rd_data, 8'h00);
    chk("drain_status", status, 8'h00);

    // read while empty has no effect
    pop_one();
    chk("empty_pop_count", {4'h0, count}, 8'h00);
    chk("empty_pop_rd", rd_data, 8'h00);

    // long rx_done level gives exactly one push
    rx_data = 8'h55;
    rx_done = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rx_done = 1'b0;
    tick();
    chk("hold_count", {4'h0, count}, 8'h01);
    chk("hold_data", rd_data, 8'h55);
    pop_one();
    chk("hold_empty", {7'h0, empty}, 8'h01);

    // overflow
    for (int i = 1; i <= 9; i++) pulse(8'(i), 3'b000);
    chk("ovf_full", {7'h0, full}, 8'h01);
    chk("ovf_count", {4'h0, count}, 8'h08);
    chk("ovf_status", status, 8'h11);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("ovf_pop%0d", i), rd_data, 8'(i));
      pop_one();
    end
    chk("ovf_drained", {7'h0, empty}, 8'h01);
    chk("ovf_sticky", status, 8'h10);
    do_clr();
    chk("clr1_status", status, 8'h00);

    // push coinciding with pop while full
    for (int i = 0; i < 8; i++) pulse(8'h10 + 8'(i), 3'b000);
    chk("sim_full", {7'h0, full}, 8'h01);
    chk("sim_head", rd_data, 8'h10);
    rx_data = 8'h77;
    rx_done = 1'b1;
    rd_en   = 1'b1;
    tick();
    rx_done = 1'b0;
    rd_en   = 1'b0;
    chk("sim_count", {4'h0, count}, 8'h08);
    chk("sim_status", status, 8'h01);
    tick();
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("sim_pop%0d", i), rd_data, 8'h10 + 8'(i));
      pop_one();
    end
    chk("sim_pop8", rd_data, 8'h77);
    pop_one();
    chk("sim_empty", {7'h0, empty}, 8'h01);

    // error filter and sticky flags
    pulse(8'h99, 3'b010);
    pulse(8'h98, 3'b100);
    chk("err_count", {4'h0, count}, 8'h00);
    chk("err_status", status, 8'h0C);
    do_clr();
    chk("clr2_status", status, 8'h00);
    pulse(8'h42, 3'b000);
    chk("post_clr_count", {4'h0, count}, 8'h01);
    chk("post_clr_data", rd_data, 8'h42);

    // async reset mid-stream
    do_clr();
    pulse(8'h61, 3'b000);
    pulse(8'h62, 3'b000);
    chk("pre_rst_count", {4'h0, count}, 8'h02);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_count", {4'h0, count}, 8'h00);
    chk("arst_empty", {7'h0, empty}, 8'h01);
    chk("arst_rd_data", rd_data, 8'h00);
    tick();
    reset = 1'b0;
    tick();
    pulse(8'h5A, 3'b000);
    tick();
    tick();
    chk("post_rst_count", {4'h0, count}, 8'h01);
    chk("post_rst_data", rd_data, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
